// File: rtl/osc_trap_pkg.sv
// osc_trap_pkg: shared region names and state-space helpers for the oscillate/climb/trap channels
package osc_trap_pkg;
  typedef enum logic [1:0] {REG_LOW, REG_CLIMB, REG_TRAP} osc_region_e;
  function automatic int osc_h(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int osc_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/osc_trap_ch.sv
// osc_trap_ch: one channel that toggles 0/1 low, climbs from H on kick, and traps at MAX (clr releases under OSC_TRAP_CLEAR_EN)
module osc_trap_ch
  import osc_trap_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         kick,
  input  logic         clr,
  output logic [W-1:0] state,
  output logic         trap,
  output logic         trap_enter
);
  localparam logic [W-1:0] H = W'(osc_h(W));
  localparam logic [W-1:0] MAX = W'(osc_max(W));
  osc_region_e region;
  logic [W-1:0] hold, next;
`ifdef OSC_TRAP_CLEAR_EN
  assign hold = clr ? '0 : state;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign hold = state;
`endif
  always_ff @(posedge clk)
    state <= !reset ? '0 : next;
  always_comb begin
    region = state == MAX ? REG_TRAP : state >= H ? REG_CLIMB : REG_LOW;
    next = !en ? state :
           region == REG_TRAP  ? hold :
           region == REG_CLIMB ? state + 1'b1 :
           kick                ? H :
           state == '0         ? W'(1) : '0;
  end
  always_comb begin
    trap = state == MAX;
    trap_enter = next == MAX && state != MAX;
  end
endmodule

// File: rtl/osc_trap_fsm_array.sv
// osc_trap_fsm_array: N_CH independent trap channels with aggregate flag, saturating trap-cycle count
// and sticky first-trap capture; OSC_TRAP_CLEAR_EN enables per-channel trap release via clr.
module osc_trap_fsm_array
  import osc_trap_pkg::*;
#(
  parameter int W = 2,
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   kick,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH*W-1:0] state_o,
  output logic [N_CH-1:0]   trap_o,
  output logic              any_trap_o,
  output logic [CNT_W-1:0]  trap_cnt_o,
  output logic              first_vld_o,
  output logic [IDX_W-1:0]  first_idx_o
);
  logic [N_CH-1:0] enter;
  logic [IDX_W-1:0] enc_idx;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    osc_trap_ch #(.W(W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (en[c]),
      .kick      (kick[c]),
      .clr       (clr[c]),
      .state     (state_o[c*W +: W]),
      .trap      (trap_o[c]),
      .trap_enter(enter[c])
    );
  end
  assign any_trap_o = |trap_o;
  // scan downward so the lowest entering channel wins
  always_comb begin
    enc_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (enter[i]) enc_idx = IDX_W'(i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      trap_cnt_o <= '0;
      first_vld_o <= 1'b0;
      first_idx_o <= '0;
    end else begin
      if (any_trap_o && trap_cnt_o != '1) trap_cnt_o <= trap_cnt_o + 1'b1;
      if (!first_vld_o && |enter) begin
        first_vld_o <= 1'b1;
        first_idx_o <= enc_idx;
      end
    end
  end
endmodule

// File: tb/tb_osc_trap_fsm_array.sv
// tb_osc_trap_fsm_array: vector table with scoreboard queue for W=2 x4, hand sequence for a W=4 channel
module tb_osc_trap_fsm_array;
  typedef struct packed {
    logic       rst;
    logic [3:0] en;
    logic [3:0] kick;
    logic [3:0] clr;
    logic [7:0] st;
    logic [2:0] cnt;
    logic       fvld;
    logic [1:0] fidx;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] en = '0, kick = '0, clr = '0;
  logic [7:0] state_o;
  logic [3:0] trap_o;
  logic any_trap_o;
  logic [2:0] trap_cnt_o;
  logic first_vld_o;
  logic [1:0] first_idx_o;

  logic reset4 = 1'b0, en4 = 1'b0, kick4 = 1'b0, clr4 = 1'b0;
  logic [3:0] state4;
  logic trap4, any4, fvld4;
  logic [2:0] cnt4;
  logic [0:0] fidx4;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[33];
  vec_t sb[$];

  always #5 clk = ~clk;

  osc_trap_fsm_array #(.W(2), .N_CH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .kick(kick), .clr(clr),
    .state_o(state_o), .trap_o(trap_o), .any_trap_o(any_trap_o),
    .trap_cnt_o(trap_cnt_o), .first_vld_o(first_vld_o), .first_idx_o(first_idx_o)
  );

  osc_trap_fsm_array #(.W(4), .N_CH(1), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .kick(kick4), .clr(clr4),
    .state_o(state4), .trap_o(trap4), .any_trap_o(any4),
    .trap_cnt_o(cnt4), .first_vld_o(fvld4), .first_idx_o(fidx4)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [3:0] traps_of(input logic [7:0] s);
    logic [3:0] t;
    for (int c = 0; c < 4; c++) t[c] = s[2*c +: 2] == 2'b11;
    return t;
  endfunction

  task automatic step4(input logic r, input logic e, input logic k);
    @(negedge clk);
    reset4 = r;
    en4 = e;
    kick4 = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s31, s32;
    logic [2:0] c32;
`ifdef OSC_TRAP_CLEAR_EN
    s31 = 8'h51; s32 = 8'h04; c32 = 3'd1;
`else
    s31 = 8'h5D; s32 = 8'h0C; c32 = 3'd2;
`endif
    // free-running oscillation, then a kick on ch2 and counter saturation
    vecs[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h55, 3'd0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h55, 3'd0, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 4'hF, 4'h4, 4'h0, 8'h65, 3'd0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h30, 3'd0, 1'b1, 2'd2};
    vecs[7]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h75, 3'd1, 1'b1, 2'd2};
    vecs[8]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h30, 3'd2, 1'b1, 2'd2};
    vecs[9]  = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h75, 3'd3, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h30, 3'd4, 1'b1, 2'd2};
    vecs[11] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h75, 3'd5, 1'b1, 2'd2};
    vecs[12] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h30, 3'd6, 1'b1, 2'd2};
    vecs[13] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h75, 3'd7, 1'b1, 2'd2};
    vecs[14] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h30, 3'd7, 1'b1, 2'd2};
    vecs[15] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h75, 3'd7, 1'b1, 2'd2};
    // simultaneous kicks on ch3/ch1, later trap on ch0
    vecs[16] = '{1'b0, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[17] = '{1'b1, 4'hF, 4'hA, 4'h0, 8'h99, 3'd0, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'hCC, 3'd0, 1'b1, 2'd1};
    vecs[19] = '{1'b1, 4'hF, 4'h1, 4'h0, 8'hDE, 3'd1, 1'b1, 2'd1};
    vecs[20] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'hCF, 3'd2, 1'b1, 2'd1};
    // ch0 disabled while kicked, then resumes
    vecs[21] = '{1'b0, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[22] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h55, 3'd0, 1'b0, 2'd0};
    vecs[23] = '{1'b1, 4'hE, 4'h1, 4'h0, 8'h01, 3'd0, 1'b0, 2'd0};
    vecs[24] = '{1'b1, 4'hE, 4'h1, 4'h0, 8'h55, 3'd0, 1'b0, 2'd0};
    vecs[25] = '{1'b1, 4'hE, 4'h0, 4'h0, 8'h01, 3'd0, 1'b0, 2'd0};
    vecs[26] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h54, 3'd0, 1'b0, 2'd0};
    vecs[27] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h01, 3'd0, 1'b0, 2'd0};
    // clr on trapped ch1 (and on non-trapped ch0)
    vecs[28] = '{1'b0, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 1'b0, 2'd0};
    vecs[29] = '{1'b1, 4'hF, 4'h2, 4'h0, 8'h59, 3'd0, 1'b0, 2'd0};
    vecs[30] = '{1'b1, 4'hF, 4'h0, 4'h0, 8'h0C, 3'd0, 1'b1, 2'd1};
    vecs[31] = '{1'b1, 4'hF, 4'h0, 4'h3, s31,   3'd1, 1'b1, 2'd1};
    vecs[32] = '{1'b1, 4'hF, 4'h0, 4'h0, s32,   c32,  1'b1, 2'd1};

    for (int i = 0; i < 33; i++) begin
      vec_t e;
      @(negedge clk);
      reset = vecs[i].rst;
      en = vecs[i].en;
      kick = vecs[i].kick;
      clr = vecs[i].clr;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("state_o", i, 32'(state_o), 32'(e.st));
      chk("trap_o", i, 32'(trap_o), 32'(traps_of(e.st)));
      chk("any_trap_o", i, 32'(any_trap_o), 32'(|traps_of(e.st)));
      chk("trap_cnt_o", i, 32'(trap_cnt_o), 32'(e.cnt));
      chk("first_vld_o", i, 32'(first_vld_o), 32'(e.fvld));
      if (e.fvld) chk("first_idx_o", i, 32'(first_idx_o), 32'(e.fidx));
    end

    // W=4: full climb from a kick at 0
    step4(1'b0, 1'b1, 1'b0);
    chk("w4_reset_state", 0, 32'(state4), 32'd0);
    chk("w4_reset_fvld", 0, 32'(fvld4), 32'd0);
    step4(1'b1, 1'b1, 1'b1);
    chk("w4_kick_state", 8, 32'(state4), 32'd8);
    for (int s = 9; s <= 15; s++) begin
      step4(1'b1, 1'b1, 1'b0);
      chk("w4_climb_state", s, 32'(state4), 32'(s));
    end
    chk("w4_trap", 15, 32'(trap4), 32'd1);
    chk("w4_fvld", 15, 32'(fvld4), 32'd1);
    chk("w4_fidx", 15, 32'(fidx4), 32'd0);
    step4(1'b1, 1'b1, 1'b1);
    chk("w4_trap_hold", 16, 32'(state4), 32'd15);
    chk("w4_cnt", 16, 32'(cnt4), 32'd1);
    // kick mid-climb ignored, reset mid-climb loses the climb
    step4(1'b0, 1'b1, 1'b0);
    chk("w4_reset2_state", 0, 32'(state4), 32'd0);
    step4(1'b1, 1'b1, 1'b1);
    step4(1'b1, 1'b1, 1'b0);
    step4(1'b1, 1'b1, 1'b0);
    chk("w4_at10", 10, 32'(state4), 32'd10);
    step4(1'b1, 1'b1, 1'b1);
    chk("w4_kick_ignored", 11, 32'(state4), 32'd11);
    step4(1'b1, 1'b1, 1'b0);
    chk("w4_at12", 12, 32'(state4), 32'd12);
    step4(1'b0, 1'b1, 1'b1);
    chk("w4_reset_mid", 0, 32'(state4), 32'd0);
    chk("w4_reset_mid_fvld", 0, 32'(fvld4), 32'd0);
    chk("w4_reset_mid_cnt", 0, 32'(cnt4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
